// File: rtl/hs_elastic_fifo.sv
// Valid/ready elastic FIFO with configurable depth, optional empty-bypass (fall-through),
// synchronous flush and occupancy output. Pointers wrap explicitly at DEPTH-1.
module hs_elastic_fifo #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 2,
  parameter bit FALL_THROUGH = 1'b0,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              push;
  logic              pop;
  logic              bypass;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty      = (count == '0);
  // Ready looks only at stored occupancy, so a pop cannot free a slot in the same cycle.
  assign in_ready_o = (count != FULL);
  assign count_o    = count;

  always_comb begin
    out_valid_o = !empty;
    out_data_o  = mem[rd_ptr];
    if (FALL_THROUGH) begin
      out_valid_o = !empty || in_valid_i;
      if (empty) out_data_o = in_data_i;
    end
  end

  assign push   = in_valid_i && in_ready_o && !flush_i;
  assign pop    = out_valid_o && out_ready_i && !flush_i;
  // Word passed straight through an empty fall-through buffer: no state changes.
  assign bypass = FALL_THROUGH && empty && push && pop;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (!bypass) begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push && !bypass) mem[wr_ptr] <= in_data_i;
  end

`ifndef SYNTHESIS
  a_in_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rst_ni && !flush_i && in_valid_i && !push) |=> in_valid_i);
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= FULL);
  a_push_ready: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> in_ready_o);
`endif

endmodule

// File: doc/hs_elastic_fifo.md
Name: hs_elastic_fifo

Overview:
- Parametrised valid/ready elastic buffer; the generalised successor of the single-stage handshake register.
- Configurable data width, depth and latency mode (registered or fall-through), with synchronous flush and occupancy output.
- Used between pipeline stages (fetch→decode, issue queues, LSU response paths) wherever a stage boundary needs more than one entry of slack.
- Both sides follow the handshake_t protocol from global_config_pkg. A transfer occurs on a rising clk_i when valid and ready are both 1.

Parameters:
- DATA_W, 32, payload width in bits (≥1)
- DEPTH, 2, number of storage entries (≥1, need not be a power of two)
- FALL_THROUGH, 0, 0 = registered output (1-cycle minimum latency); 1 = empty-bypass (0-cycle latency when empty)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, do not override)

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  synchronous clear of all entries
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  buffer can accept
- in_data_i  in  DATA_W  upstream payload
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DATA_W  head payload
- count_o  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset
  - Sampled only on a rising clk_i edge while rst_ni=0.
  - After that edge: rd_ptr=wr_ptr=0, count_o=0, out_valid_o=0, in_ready_o=1.
  - Storage array is not reset. out_data_o is don't-care whenever out_valid_o=0.
  - Reset mid-operation discards all entries. Any push or pop on the reset edge is ignored.
- Flush
  - flush_i=1 at an edge has the same effect as reset on pointers and count.
  - A push or pop presented in the flush cycle is dropped; no transfer is counted.
  - Reset has priority over flush.
- Ready and valid
  - in_ready_o = (count != DEPTH). It is registered-state only, with no combinational path from out_ready_i.
  - When full, no push is accepted even if a pop occurs in the same cycle. This is an intentional break of the timing path.
  - FALL_THROUGH=0: out_valid_o = (count != 0). out_data_o = mem[rd_ptr]. Both depend on state only.
  - FALL_THROUGH=1: out_valid_o = (count != 0) | in_valid_i. When count=0, out_data_o = in_data_i (combinational bypass); otherwise out_data_o = mem[rd_ptr].
- Transfers
  - push = in_valid_i & in_ready_o & ~flush_i
  - pop = out_valid_o & out_ready_i & ~flush_i
  - Push writes in_data_i to mem[wr_ptr] and advances wr_ptr.
  - Pop advances rd_ptr.
  - FALL_THROUGH=1 with count=0 and push&pop in the same cycle: data bypasses, nothing is written, pointers and count are unchanged.
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
  - count' = count + push − pop, and never exceeds DEPTH.
- Pointer wrap
  - Pointers are $clog2(DEPTH)-bit (min 1) indices.
  - They wrap from DEPTH−1 to 0 explicitly, not by power-of-two overflow.
  - DEPTH=1 is legal: a single entry, pointers constant 0.
- Latency
  - FALL_THROUGH=0: an entry pushed at edge N is visible on out_* after edge N.
  - FALL_THROUGH=1 and empty: visible in the same cycle as in_valid_i.
- Order and stability
  - Strict FIFO order.
  - While out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o hold stable. This is not guaranteed in fall-through bypass, where they follow the upstream, which itself must hold under protocol.
- Assertions (simulation only)
  - in_valid_i must not drop without a transfer.
  - count_o ≤ DEPTH.
  - No push when in_ready_o=0.

Test Plan:
- Reset, DEPTH=4, FALL_THROUGH=0
  - Stimulus: hold rst_ni=0 for 2 edges, release.
  - Required: count_o=0, out_valid_o=0, in_ready_o=1; a push with rst_ni=0 is ignored.
- Fill and drain, DEPTH=4, FALL_THROUGH=0, out_ready_i=0
  - Stimulus: push 0xA0..0xA3.
  - Required: count_o 1,2,3,4; in_ready_o=0 after the 4th push; a 5th push (0xA4) is not accepted.
  - Then raise out_ready_i: outputs 0xA0,0xA1,0xA2,0xA3 on successive edges, count_o returns to 0.
- Wrap-around, DEPTH=3
  - Stimulus: stream 10 words 0x00..0x09 with continuous push and pop, out_ready_i toggling every other cycle.
  - Required: output sequence 0x00..0x09 in order with no loss or duplication; pointers wrap 2→0.
- Full with simultaneous pop, DEPTH=2
  - Stimulus: buffer full, in_valid_i=1 and out_ready_i=1 in the same cycle.
  - Required: pop occurs, push rejected (in_ready_o=0), count_o 2→1; the push is accepted next cycle, count_o back to 2.
- Fall-through, FALL_THROUGH=1, DEPTH=2, empty
  - Stimulus: in_valid_i=1, in_data_i=0x5A, out_ready_i=1.
  - Required: out_valid_o=1 and out_data_o=0x5A in the same cycle; count_o stays 0.
  - With out_ready_i=0 instead: the entry is stored and count_o=1 after the edge.
- Flush mid-stream, DEPTH=4
  - Stimulus: count=3, assert flush_i with in_valid_i=1 (0x77) and out_ready_i=1.
  - Required: after the edge count_o=0, out_valid_o=0, and 0x77 is not stored; the next push of 0x88 is output first.
